pipelined_cla_adder: RTL

Parametrised, pipelined carry-lookahead adder built from 4-bit CLA groups, computing `{cout, sum} = A + B + Cin` for a configurable operand width. Carry resolution is split across register stages so wide adds close timing at one result per cycle. A valid/ready handshake on input and output lets the block sit between streaming producers and consumers in the datapath. Output packing matches the existing 4-bit adder: carry-out in the MSB of `Out`.

---
 rtl/pipelined_cla_adder_if.sv | 35 +++
 rtl/pipelined_cla_adder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Streaming operand/result bundle for pipelined_cla_adder.
// The ovf signal exists only when PIPE_CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   Out;
`ifdef PIPE_CLA_OVF_EN
   logic             ovf;
`endif

   // Producer/consumer side.
   modport master (
      output in_valid, A, B, Cin, out_ready,
      input  in_ready, out_valid, Out
`ifdef PIPE_CLA_OVF_EN
      , input ovf
`endif
   );

   // Adder side.
   modport slave (
      input  in_valid, A, B, Cin, out_ready,
      output in_ready, out_valid, Out
`ifdef PIPE_CLA_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: {cout, sum} = A + B + Cin, one 4*G-bit slice per stage.
// Define PIPE_CLA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_cla_adder #(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 1
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_cla_adder_if.slave bus
);

   localparam int G   = GROUPS_PER_STAGE;
   localparam int SW  = 4 * G;
   localparam int LAT = WIDTH / SW;

   // Handshake: a beat moves on a clock edge when valid & ready are both high;
   // a stalled result (out_valid & ~out_ready) freezes the whole pipeline.

   logic [LAT-1:0]   valid_q, valid_d;
   logic [LAT-1:0]   carry_q, carry_d;
   logic [WIDTH-1:0] a_q   [LAT];
   logic [WIDTH-1:0] a_d   [LAT];
   logic [WIDTH-1:0] b_q   [LAT];
   logic [WIDTH-1:0] b_d   [LAT];
   logic [WIDTH-1:0] sum_q [LAT];
   logic [WIDTH-1:0] sum_d [LAT];
   logic             out_valid_q, out_valid_d;
   logic [WIDTH:0]   out_q, out_d;
`ifdef PIPE_CLA_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             stall;
   logic [SW:0]      stage_r [LAT];
   logic [WIDTH-1:0] last_sum;

   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic c0);
      logic [3:0] p, g, c;
      logic       gg, pg;
      p    = a ^ b;
      g    = a & b;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg   = &p;
      return {gg | (pg & c0), p ^ c};
   endfunction

   // Groups inside one slice are cascaded on their group carry-out.
   function automatic logic [SW:0] add_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic cin);
      logic [SW-1:0] s;
      logic          c;
      logic [4:0]    t;
      s = '0;
      c = cin;
      for (int j = 0; j < G; j++) begin
         t            = cla4(a[j*4 +: 4], b[j*4 +: 4], c);
         s[j*4 +: 4]  = t[3:0];
         c            = t[4];
      end
      return {c, s};
   endfunction

   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         stage_r[k] = add_slice(a_q[k][k*SW +: SW], b_q[k][k*SW +: SW], carry_q[k]);
      end
   end

   always_comb begin
      stall       = out_valid_q & ~bus.out_ready;
      valid_d     = valid_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
`ifdef PIPE_CLA_OVF_EN
      ovf_d       = ovf_q;
`endif
      last_sum                     = sum_q[LAT-1];
      last_sum[(LAT-1)*SW +: SW]   = stage_r[LAT-1][SW-1:0];

      if (!stall) begin
         valid_d[0] = bus.in_valid;
         carry_d[0] = bus.Cin;
         a_d[0]     = bus.A;
         b_d[0]     = bus.B;
         sum_d[0]   = '0;
         for (int k = 1; k < LAT; k++) begin
            valid_d[k]                 = valid_q[k-1];
            carry_d[k]                 = stage_r[k-1][SW];
            a_d[k]                     = a_q[k-1];
            b_d[k]                     = b_q[k-1];
            sum_d[k]                   = sum_q[k-1];
            sum_d[k][(k-1)*SW +: SW]   = stage_r[k-1][SW-1:0];
         end
         out_valid_d = valid_q[LAT-1];
         out_d       = {stage_r[LAT-1][SW], last_sum};
`ifdef PIPE_CLA_OVF_EN
         // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
         ovf_d = a_q[LAT-1][WIDTH-1] ^ b_q[LAT-1][WIDTH-1] ^ last_sum[WIDTH-1]
                 ^ stage_r[LAT-1][SW];
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         carry_q     <= '0;
         for (int k = 0; k < LAT; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
         out_valid_q <= 1'b0;
         out_q       <= '0;
`ifdef PIPE_CLA_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         valid_q     <= valid_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
`ifdef PIPE_CLA_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_valid_q;
   assign bus.Out       = out_q;
`ifdef PIPE_CLA_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule
